lc3b_mem_arbiter: RTL and testbench

Two-port memory controller/arbiter for the LC-3b core: shares the single MAR/MDR memory block between the instruction-fetch port (port 0) and the load/store port (port 1). It grants one requester at a time in round-robin order, then sequences the memory's load-MAR, load-MDR, read/write and data-size controls and waits for its ready flag. Each request completes with a one-cycle acknowledge carrying read data or an error flag.

---
 rtl/lc3b_mem_pkg.sv | 37 +++
 rtl/lc3b_mem_arbiter_rr.sv | 46 ++++
 rtl/lc3b_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_mem_pkg
// Shared types and constants for the LC-3b two-port memory arbiter.
//   arb_state_e       : controller state encoding
//   PORT_FETCH/DATA   : port indices (instruction fetch / load-store)
//   SIZE_BYTE/WORD    : data-size encodings used on byte_en and mem_datasize
//   DEFAULT_TIMEOUT_CYCLES : default WAIT abort limit (MEM_ARB_TIMEOUT_EN builds)
// ---------------------------------------------------------------------------
package lc3b_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } arb_state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic SIZE_BYTE = 1'b1;
    localparam logic SIZE_WORD = 1'b0;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // A 16-bit access must be word aligned; byte accesses may use any address.
    function automatic logic is_misaligned(input logic size, input logic [15:0] addr);
        return (size == SIZE_WORD) && addr[0];
    endfunction

    // One-hot acknowledge vector for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DATA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lc3b_mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// lc3b_rr_arbiter
// Two-way round-robin arbiter with a last-grant pointer.
//   clk_50      in  : clock
//   rst_n       in  : asynchronous active-low reset (pointer resets to 1)
//   req[1:0]    in  : request levels
//   accept      in  : pointer update strobe (controller accepted a grant)
//   grant_valid out : at least one request is present
//   grant_port  out : index of the winning port
// ---------------------------------------------------------------------------
module lc3b_rr_arbiter
    import lc3b_mem_pkg::*;
(
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_port
);

    logic last_q;
    logic last_d;

    // With both ports requesting, the port not granted last time wins;
    // a lone requester always wins.
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_port = ~last_q;
        end else begin
            grant_port = req[1];
        end
        last_d = accept ? grant_port : last_q;
    end

    // Pointer resets to port 1 so port 0 wins the first simultaneous request.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3b_mem_arbiter
// Shares the LC-3b MAR/MDR memory block between the fetch port (0) and the
// load/store port (1). One request is served at a time: the MAR is loaded,
// the MDR is loaded for stores, then the controller waits for mem_ready and
// returns a one-cycle ack with read data or an error flag.
//
// Ports:
//   clk_50, rst_n            : clock, asynchronous active-low reset
//   req/we/byte_en[1:0]      : per-port request, write enable, size (1=byte)
//   addr0/addr1, wdata0/1    : per-port address and store data
//   ack[1:0], err, rdata     : completion pulse, error flag, read data
//   mem_bus, mem_ld_mar, mem_ld_mdr, mem_rw, mem_datasize : memory controls
//   mem_ready, mem_rdata     : memory handshake and MDR contents
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without mem_ready (ack with err=1, rdata=0).
// All memory-side outputs are registered: each is computed from the state
// being entered, so strobes are clean one-cycle pulses.
// ---------------------------------------------------------------------------
module lc3b_mem_arbiter
    import lc3b_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  byte_en,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] mem_bus,
    output logic        mem_ld_mar,
    output logic        mem_ld_mdr,
    output logic        mem_rw,
    output logic        mem_datasize,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata
);

    arb_state_e  state_q, state_d;

    logic        port_q, port_d;
    logic        we_q, we_d;
    logic        size_q, size_d;
    logic [15:0] wdata_q, wdata_d;

    logic [1:0]  ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] bus_q, bus_d;
    logic        ld_mar_q, ld_mar_d;
    logic        ld_mdr_q, ld_mdr_d;
    logic        rw_q, rw_d;
    logic        dsize_q, dsize_d;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

    logic        grant_valid;
    logic        grant_port;
    logic        accept;

    // Winner's request fields, selected before they are registered.
    logic        sel_we;
    logic        sel_size;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    lc3b_rr_arbiter u_rr (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .req         (req),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        sel_we    = we[grant_port];
        sel_size  = byte_en[grant_port];
        sel_addr  = grant_port ? addr1 : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
    end

    // Next-state and registered-output logic. Strobes default low; the bus
    // and rdata hold their last values unless a state loads them.
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        accept   = 1'b0;
        ack_d    = 2'b00;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        bus_d    = bus_q;
        ld_mar_d = 1'b0;
        ld_mdr_d = 1'b0;
        rw_d     = 1'b0;
        dsize_d  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    accept  = 1'b1;
                    port_d  = grant_port;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    wdata_d = sel_wdata;
                    // Misaligned word access completes at once with an error
                    // and never touches memory.
                    if (is_misaligned(sel_size, sel_addr)) begin
                        state_d = DONE;
                        ack_d   = port_onehot(grant_port);
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                    end else begin
                        state_d  = ADDR;
                        ld_mar_d = 1'b1;
                        bus_d    = sel_addr;
                        dsize_d  = sel_size;
                    end
                end
            end

            ADDR: begin
                dsize_d = size_q;
`ifdef MEM_ARB_TIMEOUT_EN
                wait_cnt_d = 16'd0;
`endif
                if (we_q) begin
                    state_d  = DATA;
                    ld_mdr_d = 1'b1;
                    rw_d     = 1'b1;
                    bus_d    = wdata_q;
                end else begin
                    state_d = WAIT;
                end
            end

            DATA: begin
                state_d = WAIT;
                rw_d    = 1'b1;
                dsize_d = size_q;
`ifdef MEM_ARB_TIMEOUT_EN
                wait_cnt_d = 16'd0;
`endif
            end

            WAIT: begin
                rw_d    = we_q;
                dsize_d = size_q;
                // mem_ready has priority over an expiring timeout.
                if (mem_ready) begin
                    state_d = DONE;
                    ack_d   = port_onehot(port_q);
                    rdata_d = we_q ? 16'h0000 : mem_rdata;
                    rw_d    = 1'b0;
                    dsize_d = 1'b0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    ack_d   = port_onehot(port_q);
                    err_d   = 1'b1;
                    rdata_d = 16'h0000;
                    rw_d    = 1'b0;
                    dsize_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transaction and output registers.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            port_q   <= PORT_FETCH;
            we_q     <= 1'b0;
            size_q   <= SIZE_WORD;
            wdata_q  <= 16'h0000;
            ack_q    <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= 16'h0000;
            bus_q    <= 16'h0000;
            ld_mar_q <= 1'b0;
            ld_mdr_q <= 1'b0;
            rw_q     <= 1'b0;
            dsize_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            bus_q    <= bus_d;
            ld_mar_q <= ld_mar_d;
            ld_mdr_q <= ld_mdr_d;
            rw_q     <= rw_d;
            dsize_q  <= dsize_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // WAIT-cycle counter, cleared on entry to WAIT.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign ack          = ack_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign mem_bus      = bus_q;
    assign mem_ld_mar   = ld_mar_q;
    assign mem_ld_mdr   = ld_mdr_q;
    assign mem_rw       = rw_q;
    assign mem_datasize = dsize_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3b_mem_arbiter
// Directed bench for lc3b_mem_arbiter. Inputs change and outputs are sampled
// 1 ns after each rising clock edge. With MEM_ARB_TIMEOUT_EN defined the
// abort path is exercised as well (TIMEOUT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_lc3b_mem_arbiter;

    logic        clk_50;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  byte_en;
    logic [15:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  ack;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] mem_bus;
    logic        mem_ld_mar, mem_ld_mdr, mem_rw, mem_datasize;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lc3b_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .byte_en      (byte_en),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .mem_bus      (mem_bus),
        .mem_ld_mar   (mem_ld_mar),
        .mem_ld_mdr   (mem_ld_mdr),
        .mem_rw       (mem_rw),
        .mem_datasize (mem_datasize),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        rst_n = 1'b0;
        #1;
        outs = {ack, err, rdata, mem_ld_mar, mem_ld_mdr, mem_rw, mem_datasize};
        n_checks++;
        if (outs !== 23'd0 || mem_bus !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got outs=%h bus=%h, expected 0/0", outs, mem_bus);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (ack !== 2'b00 || mem_ld_mar !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got ack=%b ld_mar=%b, expected 00/0", ack, mem_ld_mar);
        end
    endtask

    task automatic test_read_port0();
        req = 2'b01; we = 2'b00; byte_en = 2'b00; addr0 = 16'h3000;
        step();
        n_checks++;
        if (mem_ld_mar !== 1'b1 || mem_bus !== 16'h3000 || mem_datasize !== 1'b0 || mem_ld_mdr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read0_addr: got mar=%b bus=%h size=%b mdr=%b, expected 1/3000/0/0",
                     mem_ld_mar, mem_bus, mem_datasize, mem_ld_mdr);
        end
        // mem_ready during ADDR must be ignored
        mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ack !== 2'b00 || mem_ld_mar !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL read0_wait%0d: got ack=%b mar=%b, expected 00/0", i, ack, mem_ld_mar);
            end
            step();
        end
        mem_ready = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (ack !== 2'b01 || rdata !== 16'h1234 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read0_ack: got ack=%b rdata=%h err=%b, expected 01/1234/0", ack, rdata, err);
        end
        req = 2'b00;
        step();
        n_checks++;
        if (ack !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL read0_ack_width: got ack=%b, expected 00", ack);
        end
    endtask

    task automatic test_byte_write_port1();
        req = 2'b10; we = 2'b10; byte_en = 2'b10; addr1 = 16'h0001; wdata1 = 16'h0007;
        step();
        n_checks++;
        if (mem_ld_mar !== 1'b1 || mem_bus !== 16'h0001 || mem_datasize !== 1'b1 || mem_rw !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wr1_addr: got mar=%b bus=%h size=%b rw=%b, expected 1/0001/1/0",
                     mem_ld_mar, mem_bus, mem_datasize, mem_rw);
        end
        step();
        n_checks++;
        if (mem_ld_mdr !== 1'b1 || mem_ld_mar !== 1'b0 || mem_bus !== 16'h0007 || mem_rw !== 1'b1 || mem_datasize !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr1_data: got mdr=%b mar=%b bus=%h rw=%b size=%b, expected 1/0/0007/1/1",
                     mem_ld_mdr, mem_ld_mar, mem_bus, mem_rw, mem_datasize);
        end
        step();
        n_checks++;
        if (mem_ld_mdr !== 1'b0 || mem_rw !== 1'b1 || mem_datasize !== 1'b1 || ack !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL wr1_wait: got mdr=%b rw=%b size=%b ack=%b, expected 0/1/1/00",
                     mem_ld_mdr, mem_rw, mem_datasize, ack);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (ack !== 2'b10 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wr1_ack: got ack=%b err=%b, expected 10/0", ack, err);
        end
        req = 2'b00; we = 2'b00; byte_en = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [15:0] exp_bus [4] = '{16'h1000, 16'h2000, 16'h1000, 16'h2000};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        req = 2'b11; we = 2'b00; byte_en = 2'b00; addr0 = 16'h1000; addr1 = 16'h2000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (mem_ld_mar !== 1'b1 || mem_bus !== exp_bus[i]) begin
                n_fail++;
                $display("[TB] FAIL rr_addr%0d: got mar=%b bus=%h, expected 1/%h", i, mem_ld_mar, mem_bus, exp_bus[i]);
            end
            step();
            mem_ready = 1'b1; mem_rdata = 16'hA000 + 16'(i);
            step();
            mem_ready = 1'b0;
            n_checks++;
            if (ack !== exp_ack[i] || rdata !== (16'hA000 + 16'(i))) begin
                n_fail++;
                $display("[TB] FAIL rr_ack%0d: got ack=%b rdata=%h, expected %b/%h",
                         i, ack, rdata, exp_ack[i], 16'hA000 + 16'(i));
            end
            if (i == 3) req = 2'b00;
            step();
        end
        step();
        n_checks++;
        if (mem_ld_mar !== 1'b0 || ack !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL rr_quiet: got mar=%b ack=%b, expected 0/00", mem_ld_mar, ack);
        end
    endtask

    task automatic test_misaligned();
        req = 2'b10; we = 2'b00; byte_en = 2'b00; addr1 = 16'h4001;
        step();
        n_checks++;
        if (ack !== 2'b10 || err !== 1'b1 || mem_ld_mar !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mis_rd1: got ack=%b err=%b mar=%b, expected 10/1/0", ack, err, mem_ld_mar);
        end
        req = 2'b00;
        step();
        n_checks++;
        if (ack !== 2'b00 || err !== 1'b0 || mem_ld_mar !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mis_after: got ack=%b err=%b mar=%b, expected 00/0/0", ack, err, mem_ld_mar);
        end
        req = 2'b01; we = 2'b01; byte_en = 2'b00; addr0 = 16'h0003; wdata0 = 16'h5555;
        step();
        n_checks++;
        if (ack !== 2'b01 || err !== 1'b1 || mem_ld_mdr !== 1'b0 || mem_ld_mar !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mis_wr0: got ack=%b err=%b mdr=%b mar=%b, expected 01/1/0/0",
                     ack, err, mem_ld_mdr, mem_ld_mar);
        end
        // odd address is legal for a byte access
        req = 2'b01; we = 2'b00; byte_en = 2'b01; addr0 = 16'h0005;
        step();
        step();
        n_checks++;
        if (mem_ld_mar !== 1'b1 || mem_bus !== 16'h0005 || mem_datasize !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL odd_byte: got mar=%b bus=%h size=%b, expected 1/0005/1", mem_ld_mar, mem_bus, mem_datasize);
        end
        step();
        mem_ready = 1'b1; mem_rdata = 16'hFF80;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (ack !== 2'b01 || rdata !== 16'hFF80 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL odd_byte_ack: got ack=%b rdata=%h err=%b, expected 01/FF80/0", ack, rdata, err);
        end
        req = 2'b00; byte_en = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        req = 2'b01; we = 2'b01; byte_en = 2'b01; addr0 = 16'h0100; wdata0 = 16'h00AB;
        step();
        step();
        step();
        n_checks++;
        if (mem_rw !== 1'b1 || mem_datasize !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_pre: got rw=%b size=%b, expected 1/1", mem_rw, mem_datasize);
        end
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00; byte_en = 2'b00;
        #1;
        n_checks++;
        if (mem_rw !== 1'b0 || mem_datasize !== 1'b0 || mem_bus !== 16'h0000 || ack !== 2'b00 || rdata !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL rst_mid: got rw=%b size=%b bus=%h ack=%b rdata=%h, expected all 0",
                     mem_rw, mem_datasize, mem_bus, ack, rdata);
        end
        step();
        rst_n = 1'b1;
        req = 2'b10; addr1 = 16'h0040;
        step();
        n_checks++;
        if (mem_ld_mar !== 1'b1 || mem_bus !== 16'h0040) begin
            n_fail++;
            $display("[TB] FAIL rst_new_addr: got mar=%b bus=%h, expected 1/0040", mem_ld_mar, mem_bus);
        end
        step();
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (ack !== 2'b10 || rdata !== 16'hBEEF || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_new_ack: got ack=%b rdata=%h err=%b, expected 10/BEEF/0", ack, rdata, err);
        end
        req = 2'b00;
        step();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req = 2'b01; we = 2'b00; byte_en = 2'b00; addr0 = 16'h0200;
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if (ack !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL tmo_early%0d: got ack=%b, expected 00", i, ack);
            end
        end
        step();
        n_checks++;
        if (ack !== 2'b01 || err !== 1'b1 || rdata !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL tmo_ack: got ack=%b err=%b rdata=%h, expected 01/1/0000", ack, err, rdata);
        end
        req = 2'b00;
        step();
    endtask
`endif

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00; byte_en = 2'b00;
        addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
        mem_ready = 1'b0; mem_rdata = 16'h0000;
        #2;
        test_reset();
        test_read_port0();
        test_byte_write_port1();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
